// File: rtl/servo_pkg.sv
// Shared servo constants, motion state encoding and target clamp helper.
package servo_pkg;

    localparam int unsigned SERVO_MIN_US  = 500;
    localparam int unsigned SERVO_MAX_US  = 2500;
    localparam int unsigned SERVO_INIT_US = 1500;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE   = 2'd1,
        SETTLE = 2'd2
    } servo_state_t;

    function automatic logic [15:0] clamp_us(input logic [15:0] v,
                                             input logic [15:0] lo,
                                             input logic [15:0] hi);
        if (v < lo)
            return lo;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

endpackage

// File: rtl/servo_motion_sched_if.sv
// Request handshakes from the manual (Bluetooth) and auto (camera) sources.
interface servo_motion_sched_if;
    logic        m_valid;
    logic [15:0] m_pulse_us;
    logic        m_ready;
    logic        a_valid;
    logic [15:0] a_pulse_us;
    logic        a_ready;

    modport master (
        output m_valid, m_pulse_us, a_valid, a_pulse_us,
        input  m_ready, a_ready
    );

    modport slave (
        input  m_valid, m_pulse_us, a_valid, a_pulse_us,
        output m_ready, a_ready
    );
endinterface

// File: rtl/servo_req_arb.sv
// Two-way fixed-priority request arbiter: manual always wins, auto only in idle.
module servo_req_arb (
    input  logic        idle,
    input  logic        m_valid,
    input  logic [15:0] m_pulse_us,
    input  logic        a_valid,
    input  logic [15:0] a_pulse_us,
    output logic        m_ready,
    output logic        a_ready,
    output logic        grant,
    output logic        grant_owner,
    output logic [15:0] grant_us
);

    // Manual is always ready; auto is held off while moving or while manual asks.
    always_comb begin
        m_ready     = 1'b1;
        a_ready     = idle && !m_valid;
        grant       = m_valid || (a_valid && a_ready);
        grant_owner = !m_valid;
        grant_us    = m_valid ? m_pulse_us : a_pulse_us;
    end

endmodule

// File: rtl/servo_motion_sched.sv
// Motion scheduler: accepts clamped targets and slews the PWM pulse width
// toward them by at most STEP_US per frame, then reports done after settling.
module servo_motion_sched
    import servo_pkg::*;
#(
    parameter int unsigned MIN_US        = SERVO_MIN_US,
    parameter int unsigned MAX_US        = SERVO_MAX_US,
    parameter int unsigned INIT_US       = SERVO_INIT_US,
    parameter int unsigned STEP_US       = 20,
    parameter int unsigned SETTLE_FRAMES = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_tick,
    input  logic                      hold,
    servo_motion_sched_if.slave       req,
    output logic [15:0]               pulse_us,
    output logic                      busy,
    output logic                      done,
    output logic                      owner
);

    localparam int unsigned CW = $clog2(SETTLE_FRAMES + 1);

    servo_state_t    state, state_n;
    logic [15:0]     target, target_n;
    logic [15:0]     pulse_q, pulse_n;
    logic [CW-1:0]   settle_cnt, settle_cnt_n;
    logic            owner_q, owner_n;
    logic            done_q, done_n;

    logic            idle;
    logic            grant;
    logic            grant_owner;
    logic [15:0]     grant_us;
    logic signed [16:0] diff;
    logic [16:0]     mag;

    servo_req_arb u_arb (
        .idle        (idle),
        .m_valid     (req.m_valid),
        .m_pulse_us  (req.m_pulse_us),
        .a_valid     (req.a_valid),
        .a_pulse_us  (req.a_pulse_us),
        .m_ready     (req.m_ready),
        .a_ready     (req.a_ready),
        .grant       (grant),
        .grant_owner (grant_owner),
        .grant_us    (grant_us)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            target     <= 16'(INIT_US);
            pulse_q    <= 16'(INIT_US);
            settle_cnt <= '0;
            owner_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_n;
            target     <= target_n;
            pulse_q    <= pulse_n;
            settle_cnt <= settle_cnt_n;
            owner_q    <= owner_n;
            done_q     <= done_n;
        end
    end

    // Next state: an accept (including preemption) beats any frame step;
    // otherwise each unheld tick moves one step or advances the settle count.
    always_comb begin
        state_n      = state;
        target_n     = target;
        pulse_n      = pulse_q;
        settle_cnt_n = settle_cnt;
        owner_n      = owner_q;
        done_n       = 1'b0;
        diff         = $signed({1'b0, target}) - $signed({1'b0, pulse_q});
        mag          = diff[16] ? 17'(-diff) : 17'(diff);
        if (grant) begin
            target_n     = clamp_us(grant_us, 16'(MIN_US), 16'(MAX_US));
            owner_n      = grant_owner;
            state_n      = MOVE;
            settle_cnt_n = '0;
        end else if (frame_tick && !hold) begin
            unique case (state)
                MOVE: begin
                    if (mag <= 17'(STEP_US)) begin
                        pulse_n      = target;
                        state_n      = SETTLE;
                        settle_cnt_n = '0;
                    end else if (diff[16]) begin
                        pulse_n = pulse_q - 16'(STEP_US);
                    end else begin
                        pulse_n = pulse_q + 16'(STEP_US);
                    end
                end
                SETTLE: begin
                    settle_cnt_n = settle_cnt + 1'b1;
                    if (settle_cnt_n == CW'(SETTLE_FRAMES)) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs derived from the registered state.
    always_comb begin
        idle     = (state == IDLE);
        busy     = (state != IDLE);
        pulse_us = pulse_q;
        done     = done_q;
        owner    = owner_q;
    end

endmodule

// File: tb/tb_servo_motion_sched.sv
// Self-checking bench for servo_motion_sched: directed table, hand sequences
// and randomized traffic against a behavioural frame-level model.
module tb_servo_motion_sched;

    localparam int MIN_US = 500;
    localparam int MAX_US = 2500;
    localparam int INIT_US = 1500;
    localparam int STEP = 20;
    localparam int SETTLE = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_tick = 1'b0;
    logic hold = 1'b0;
    logic [15:0] pulse_us;
    logic busy, done, owner;

    servo_motion_sched_if sif ();

    servo_motion_sched #(
        .MIN_US(MIN_US), .MAX_US(MAX_US), .INIT_US(INIT_US),
        .STEP_US(STEP), .SETTLE_FRAMES(SETTLE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .hold(hold),
        .req(sif), .pulse_us(pulse_us), .busy(busy), .done(done), .owner(owner)
    );

    always #10 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model: where the servo is, where it is going, and how many
    // frames it has already sat on the target.
    int  m_pulse, m_target, m_held;
    bit  m_active, m_arrived, m_done, m_owner;

    function automatic int clampi(input int v);
        return (v < MIN_US) ? MIN_US : (v > MAX_US) ? MAX_US : v;
    endfunction

    function automatic int absi(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        m_pulse = INIT_US; m_target = INIT_US; m_held = 0;
        m_active = 0; m_arrived = 0; m_done = 0; m_owner = 0;
    endtask

    task automatic model_step(input bit ft, input bit hd, input bit mv, input int mu,
                              input bit av, input int au);
        bit aready;
        aready = !m_active && !mv;
        m_done = 0;
        if (mv || (av && aready)) begin
            m_target = clampi(mv ? mu : au);
            m_owner = !mv;
            m_active = 1; m_arrived = 0; m_held = 0;
        end else if (ft && !hd && m_active) begin
            if (!m_arrived) begin
                if (absi(m_target - m_pulse) <= STEP) begin
                    m_pulse = m_target; m_arrived = 1; m_held = 0;
                end else begin
                    m_pulse = m_pulse + ((m_target > m_pulse) ? STEP : -STEP);
                end
            end else begin
                m_held++;
                if (m_held == SETTLE) begin
                    m_active = 0; m_done = 1;
                end
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, check ready before the edge, outputs after.
    task automatic cyc(input bit ft, input bit hd, input bit mv, input int mu,
                       input bit av, input int au);
        @(negedge clk);
        frame_tick = ft; hold = hd;
        sif.m_valid = mv; sif.m_pulse_us = 16'(mu);
        sif.a_valid = av; sif.a_pulse_us = 16'(au);
        #1;
        chk("m_ready", int'(sif.m_ready), 1);
        chk("a_ready", int'(sif.a_ready), int'(!m_active && !mv));
        model_step(ft, hd, mv, mu, av, au);
        @(posedge clk);
        #1;
        chk("pulse_us", int'(pulse_us), m_pulse);
        chk("busy", int'(busy), int'(m_active));
        chk("done", int'(done), int'(m_done));
        chk("owner", int'(owner), int'(m_owner));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        frame_tick = 0; hold = 0;
        sif.m_valid = 0; sif.a_valid = 0; sif.m_pulse_us = '0; sif.a_pulse_us = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // Tick until the DUT reports done; returns how many done pulses were seen.
    task automatic run_until_done(input string name, input int bound, output int ndone);
        int n;
        ndone = 0;
        n = 0;
        while (n < bound) begin
            cyc(1, 0, 0, 0, 0, 0);
            chk({name, "_range"}, int'(pulse_us >= 16'(MIN_US) && pulse_us <= 16'(MAX_US)), 1);
            n++;
            if (done) begin
                ndone++;
                break;
            end
        end
        if (n >= bound) chk({name, "_timeout"}, 0, 1);
    endtask

    typedef struct {
        bit ft; bit hd; bit mv; int mu; bit av; int au;
        int e_pulse; bit e_busy; bit e_done; bit e_owner;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        int n;
        sif.m_valid = 0; sif.a_valid = 0; sif.m_pulse_us = '0; sif.a_pulse_us = '0;
        model_reset();

        // Manual move 1500 -> 1600: five step ticks, five settle ticks, done.
        tbl[0] = '{0, 0, 1, 1600, 0, 0, 1500, 1, 0, 0};
        for (int i = 1; i <= 5; i++)
            tbl[i] = '{1, 0, 0, 0, 0, 0, 1500 + 20 * i, 1, 0, 0};
        for (int i = 6; i <= 9; i++)
            tbl[i] = '{1, 0, 0, 0, 0, 0, 1600, 1, 0, 0};
        tbl[10] = '{1, 0, 0, 0, 0, 0, 1600, 0, 1, 0};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 1600, 0, 0, 0};

        // Reset asserted mid-cycle.
        #5 rst_n = 1'b0;
        #30 rst_n = 1'b1;
        #1;
        chk("rst_pulse", int'(pulse_us), 1500);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_owner", int'(owner), 0);
        chk("rst_m_ready", int'(sif.m_ready), 1);
        chk("rst_a_ready", int'(sif.a_ready), 1);

        foreach (tbl[i]) begin
            cyc(tbl[i].ft, tbl[i].hd, tbl[i].mv, tbl[i].mu, tbl[i].av, tbl[i].au);
            chk($sformatf("tbl%0d_pulse", i), int'(pulse_us), tbl[i].e_pulse);
            chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_done", i), int'(done), int'(tbl[i].e_done));
            chk($sformatf("tbl%0d_owner", i), int'(owner), int'(tbl[i].e_owner));
        end

        // Clamp: manual above the top bound, then auto below the bottom bound.
        cyc(0, 0, 1, 3000, 0, 0);
        run_until_done("clamp_hi", 200, nd);
        chk("clamp_hi_final", int'(pulse_us), 2500);
        cyc(0, 0, 0, 0, 1, 100);
        chk("clamp_lo_owner", int'(owner), 1);
        run_until_done("clamp_lo", 300, nd);
        chk("clamp_lo_final", int'(pulse_us), 500);

        // Simultaneous requests: manual wins, auto waits for idle then moves.
        cyc(0, 0, 1, 1000, 1, 2000);
        chk("sim_owner", int'(owner), 0);
        n = 0;
        while (n < 200 && !(m_active && m_owner)) begin
            cyc(1, 0, 0, 0, 1, 2000);
            n++;
        end
        chk("sim_auto_taken", int'(owner), 1);
        chk("sim_auto_pulse", int'(pulse_us), 1000);

        // Preempt the auto move at 1700 with a manual request for 1000.
        n = 0;
        while (n < 100 && pulse_us != 16'd1700) begin
            cyc(1, 0, 0, 0, 0, 0);
            n++;
        end
        chk("pre_reach_1700", int'(pulse_us), 1700);
        cyc(0, 0, 1, 1000, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("pre_first_step", int'(pulse_us), 1680);
        run_until_done("pre", 200, nd);
        chk("pre_done_count", nd, 1);
        chk("pre_final", int'(pulse_us), 1000);
        chk("pre_owner", int'(owner), 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("pre_done_once", int'(done), 0);

        // Hold mid-move freezes the pulse, then motion resumes.
        cyc(0, 0, 1, 1200, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 0, 0, 0);
            chk("hold_frozen", int'(pulse_us), 1040);
        end
        cyc(1, 0, 0, 0, 0, 0);
        chk("hold_resume", int'(pulse_us), 1060);
        // Hold during settle delays done by the held frames.
        n = 0;
        while (n < 50 && pulse_us != 16'd1200) begin
            cyc(1, 0, 0, 0, 0, 0);
            n++;
        end
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
        chk("hold_settle_busy", int'(busy), 1);
        cyc(1, 0, 0, 0, 0, 0);
        chk("hold_settle_done", int'(done), 1);

        // Reset in the middle of a move returns to the reset state at once.
        cyc(0, 0, 1, 2000, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
        chk("rm_moving", int'(pulse_us), 1260);
        @(negedge clk);
        frame_tick = 0; sif.m_valid = 0;
        #3 rst_n = 1'b0;
        #1;
        chk("rm_async_pulse", int'(pulse_us), 1500);
        chk("rm_async_busy", int'(busy), 0);
        do_reset();

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(3) == 0, $urandom_range(9) == 0,
                $urandom_range(29) == 0, int'($urandom_range(3200)),
                $urandom_range(5) == 0, int'($urandom_range(3200)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
